// File: rtl/freeze_recovery_gate.sv
// Artifact gate: holds the last clean sample while freeze is flagged, then ramps
// linearly from the held anchor back to live input over 2^RAMP_SHIFT samples.
module freeze_recovery_gate #(
   parameter int WIDTH      = 16,
   parameter int RAMP_SHIFT = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    freeze,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_sample,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_sample,
   input  logic                    out_ready,
   output logic [1:0]              state,
   output logic [15:0]             freeze_events,
   output logic [15:0]             blanked_count
);

   typedef enum logic [1:0] {
      PASS = 2'd0,
      HOLD = 2'd1,
      RAMP = 2'd2
   } state_t;

   localparam int PW = WIDTH + RAMP_SHIFT + 2;
   localparam logic [RAMP_SHIFT-1:0] K_ONE  = RAMP_SHIFT'(1);
   localparam logic [RAMP_SHIFT-1:0] K_LAST = '1;

   state_t cur, nxt;

   logic                    xfer;
   logic signed [WIDTH-1:0] anchor, anchor_nxt, emit, blend;
   logic [RAMP_SHIFT-1:0]   k, k_nxt, blend_k;
   logic signed [WIDTH:0]   diff;
   logic signed [PW-1:0]    prod, shifted, sum;
   logic                    ev_inc, bl_inc;

   assign in_ready = !out_valid || out_ready;
   assign xfer     = in_valid && in_ready;
   assign state    = cur;

   // The HOLD->RAMP transfer already emits the k=1 blend, so k is forced there.
   assign blend_k = (cur == HOLD) ? K_ONE : k;

   always_comb begin
      diff    = $signed({in_sample[WIDTH-1], in_sample}) - $signed({anchor[WIDTH-1], anchor});
      prod    = $signed({{(PW-WIDTH-1){diff[WIDTH]}}, diff}) *
                $signed({{(PW-RAMP_SHIFT){1'b0}}, blend_k});
      shifted = prod >>> RAMP_SHIFT;
      sum     = $signed({{(PW-WIDTH){anchor[WIDTH-1]}}, anchor}) + shifted;
      if (sum[PW-1:WIDTH-1] == '0 || sum[PW-1:WIDTH-1] == '1)
         blend = sum[WIDTH-1:0];
      else if (sum[PW-1])
         blend = {1'b1, {(WIDTH-1){1'b0}}};
      else
         blend = {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= PASS;
      else        cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      if (xfer) begin
         case (cur)
            PASS:    if (freeze) nxt = HOLD;
            HOLD:    if (!freeze) nxt = (RAMP_SHIFT == 1) ? PASS : RAMP;
            RAMP:    if (freeze) nxt = HOLD;
                     else if (k == K_LAST) nxt = PASS;
            default: nxt = PASS;
         endcase
      end
   end

   always_comb begin
      emit       = out_sample;
      anchor_nxt = anchor;
      k_nxt      = k;
      ev_inc     = 1'b0;
      bl_inc     = 1'b0;
      case (cur)
         PASS: begin
            if (freeze) begin
               emit   = anchor;
               ev_inc = 1'b1;
               bl_inc = 1'b1;
            end else begin
               emit       = in_sample;
               anchor_nxt = in_sample;
            end
         end
         HOLD: begin
            if (freeze) begin
               emit   = anchor;
               bl_inc = 1'b1;
            end else begin
               emit  = blend;
               k_nxt = (RAMP_SHIFT == 1) ? '0 : K_ONE + K_ONE;
            end
         end
         RAMP: begin
            if (freeze) begin
               // Re-freeze mid-ramp: the last emitted blend becomes the new anchor.
               emit       = out_sample;
               anchor_nxt = out_sample;
               k_nxt      = '0;
               ev_inc     = 1'b1;
               bl_inc     = 1'b1;
            end else begin
               emit  = blend;
               k_nxt = (k == K_LAST) ? '0 : k + K_ONE;
            end
         end
         default: begin
            emit = out_sample;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_sample    <= '0;
         anchor        <= '0;
         k             <= '0;
         freeze_events <= '0;
         blanked_count <= '0;
      end else if (xfer) begin
         out_valid  <= 1'b1;
         out_sample <= emit;
         anchor     <= anchor_nxt;
         k          <= k_nxt;
         if (ev_inc && freeze_events != '1) freeze_events <= freeze_events + 16'd1;
         if (bl_inc && blanked_count != '1) blanked_count <= blanked_count + 16'd1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_freeze_recovery_gate.sv
// Directed bench for freeze_recovery_gate with RAMP_SHIFT=2 (4-sample ramp).
module tb_freeze_recovery_gate;

   logic               clk;
   logic               rst_n;
   logic               freeze;
   logic               in_valid;
   logic signed [15:0] in_sample;
   logic               in_ready;
   logic               out_valid;
   logic signed [15:0] out_sample;
   logic               out_ready;
   logic [1:0]         state;
   logic [15:0]        freeze_events;
   logic [15:0]        blanked_count;

   int total = 0;
   int bad   = 0;
   int held;

   freeze_recovery_gate #(.WIDTH(16), .RAMP_SHIFT(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .freeze        (freeze),
      .in_valid      (in_valid),
      .in_sample     (in_sample),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_sample    (out_sample),
      .out_ready     (out_ready),
      .state         (state),
      .freeze_events (freeze_events),
      .blanked_count (blanked_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One accepted sample; outputs sampled 1 time unit after the edge.
   task automatic xfer(input string tag, input logic f, input int din, input int exp_out,
                       input int exp_state);
      freeze    = f;
      in_valid  = 1'b1;
      in_sample = 16'(din);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_out"}, int'(out_sample), exp_out);
      chk({tag, "_state"}, int'(state), exp_state);
   endtask

   task automatic counters(input string tag, input int fe, input int bc);
      chk({tag, "_fe"}, int'(freeze_events), fe);
      chk({tag, "_bc"}, int'(blanked_count), bc);
   endtask

   initial begin
      rst_n     = 1'b0;
      freeze    = 1'b0;
      in_valid  = 1'b0;
      in_sample = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_out", int'(out_sample), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_ready", int'(in_ready), 1);
      counters("rst", 0, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", int'(in_ready), 1);

      // Pass-through
      xfer("pt0", 1'b0, 10, 10, 0);
      xfer("pt1", 1'b0, -20, -20, 0);
      xfer("pt2", 1'b0, 30, 30, 0);

      // Hold then ramp from 100 toward 500
      xfer("hr_a", 1'b0, 100, 100, 0);
      xfer("hr_h0", 1'b1, 30000, 100, 1);
      xfer("hr_h1", 1'b1, 30000, 100, 1);
      xfer("hr_h2", 1'b1, 30000, 100, 1);
      xfer("hr_r1", 1'b0, 500, 200, 2);
      xfer("hr_r2", 1'b0, 500, 300, 2);
      xfer("hr_r3", 1'b0, 500, 400, 0);
      xfer("hr_p", 1'b0, 500, 500, 0);
      counters("hr", 1, 3);

      // Floor rounding toward negative infinity
      xfer("fl_a", 1'b0, 0, 0, 0);
      xfer("fl_h", 1'b1, 5, 0, 1);
      xfer("fl_n1", 1'b0, -1, -1, 2);
      xfer("fl_n2", 1'b0, -1, -1, 2);
      xfer("fl_n3", 1'b0, -1, -1, 0);
      xfer("fl_b", 1'b0, 0, 0, 0);
      xfer("fl_h2", 1'b1, 5, 0, 1);
      xfer("fl_p1", 1'b0, 1, 0, 2);
      xfer("fl_p2", 1'b0, 1, 0, 2);
      xfer("fl_p3", 1'b0, 1, 0, 0);
      xfer("fl_pp", 1'b0, 1, 1, 0);
      counters("fl", 3, 5);

      // Re-freeze mid-ramp re-anchors at the last blended output
      xfer("rf_a", 1'b0, 100, 100, 0);
      xfer("rf_h", 1'b1, 7, 100, 1);
      xfer("rf_r1", 1'b0, 500, 200, 2);
      xfer("rf_rh", 1'b1, 999, 200, 1);
      counters("rf", 5, 7);
      xfer("rf_s1", 1'b0, 500, 275, 2);
      xfer("rf_s2", 1'b0, 500, 350, 2);
      xfer("rf_s3", 1'b0, 500, 425, 0);
      xfer("rf_p", 1'b0, 500, 500, 0);

      // Full-scale swing needs the extra diff bit
      xfer("fs_a", 1'b0, -32768, -32768, 0);
      xfer("fs_h", 1'b1, 0, -32768, 1);
      xfer("fs_r1", 1'b0, 32767, -16385, 2);
      xfer("fs_r2", 1'b0, 32767, -1, 2);
      xfer("fs_r3", 1'b0, 32767, 16383, 0);
      counters("fs", 6, 8);

      // Back-pressure while in HOLD: nothing moves, freeze ignored
      xfer("bp_a", 1'b0, 50, 50, 0);
      xfer("bp_h", 1'b1, 9, 50, 1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sample = 16'sd1234;
      #1;
      chk("bp_ready", int'(in_ready), 0);
      held = int'(out_sample);
      for (int i = 0; i < 5; i++) begin
         freeze = i[0];
         @(posedge clk);
         #1;
         chk("bp_stall_ready", int'(in_ready), 0);
         chk("bp_stall_valid", int'(out_valid), 1);
         chk("bp_stall_out", int'(out_sample), 50);
         chk("bp_stall_state", int'(state), 1);
         counters("bp_stall", 7, 9);
      end
      chk("bp_held", int'(out_sample), held);
      out_ready = 1'b1;
      xfer("bp_r1", 1'b0, 450, 150, 2);

      // Idle cycle with out_ready high drops out_valid; state stays put
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_state", int'(state), 2);

      // Asynchronous reset mid-RAMP, away from any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", int'(out_valid), 0);
      chk("ar_out", int'(out_sample), 0);
      chk("ar_state", int'(state), 0);
      chk("ar_ready", int'(in_ready), 1);
      counters("ar", 0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      xfer("ar_p", 1'b0, 7, 7, 0);
      xfer("ar_h", 1'b1, 3, 7, 1);
      counters("ar_post", 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freeze_recovery_gate.md
FREEZE_RECOVERY_GATE -- requirements
Module: freeze_recovery_gate

Interface
REQ-001 Parameter WIDTH, default 16: sample width, signed two's complement.
REQ-002 Parameter RAMP_SHIFT, default 6: ramp length is RAMP_LEN = 2^RAMP_SHIFT samples; legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 freeze  input  1  artifact flag from the signal guard stage; level signal.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_sample  input  WIDTH signed  upstream sample.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 out_valid  output  1  output sample valid.
REQ-010 out_sample  output  WIDTH signed  gated/blended sample.
REQ-011 out_ready  input  1  downstream accepts the output this cycle.
REQ-012 state  output  2  current FSM state: 0 PASS, 1 HOLD, 2 RAMP; 3 never driven.
REQ-013 freeze_events  output  16  count of PASS/RAMP->HOLD entries, saturating at 0xFFFF.
REQ-014 blanked_count  output  16  count of samples emitted in HOLD, saturating at 0xFFFF.

Function
REQ-015 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-016 Transfer ("xfer") SHALL mean in_valid && in_ready; state, anchor, ramp counter and stat counters change only on xfer.
REQ-017 On xfer, out_valid SHALL be 1 and out_sample SHALL be registered; latency is exactly 1 cycle.
REQ-018 If out_ready is high and there is no xfer, out_valid SHALL clear; out_sample SHALL hold stable while out_valid && !out_ready.
REQ-019 freeze SHALL be sampled only on xfer cycles; its value at xfer decides the transition.
REQ-020 PASS, xfer, freeze=0: out_sample = in_sample; anchor <= in_sample; stay PASS.
REQ-021 PASS, xfer, freeze=1: out_sample = anchor; go HOLD; freeze_events++ and blanked_count++; in_sample discarded.
REQ-022 HOLD, xfer, freeze=1: out_sample = anchor; blanked_count++; stay HOLD.
REQ-023 HOLD, xfer, freeze=0: go RAMP with k=1 and emit the k=1 blend (REQ-024) of this in_sample.
REQ-024 Blend: diff = in_sample - anchor at WIDTH+1 bits; out = anchor + ((diff*k) >>> RAMP_SHIFT), arithmetic shift (floor), result saturated to WIDTH-bit signed range.
REQ-025 RAMP, xfer, freeze=0: emit blend with current k; then k++; after emitting k = RAMP_LEN-1, go PASS (next xfer is pass-through).
REQ-026 RAMP, xfer, freeze=1: anchor <= previous out_sample; out_sample = that value; k <= 0; go HOLD; freeze_events++ and blanked_count++.
REQ-027 Anchor SHALL NOT change in HOLD or in RAMP except per REQ-026.
REQ-028 Counters SHALL saturate, never wrap; k SHALL be RAMP_SHIFT bits and never exceed RAMP_LEN-1.
REQ-029 Back-pressure (out_ready=0 with out_valid=1) SHALL stall all state; freeze changes during the stall are ignored.

Reset
REQ-030 rst_n low SHALL immediately force: out_valid=0, out_sample=0, state=PASS, anchor=0, k=0, freeze_events=0, blanked_count=0.
REQ-031 Reset asserted mid-HOLD or mid-RAMP SHALL abandon the episode; the first xfer after release follows PASS rules.
REQ-032 in_ready SHALL be 1 during and directly after reset (out_valid=0).

Verification (RAMP_SHIFT=2, RAMP_LEN=4, out_ready=1 unless stated)
REQ-033 Pass-through: samples 10, -20, 30 with freeze=0 -> outputs 10, -20, 30 one cycle later; state stays 0.
REQ-034 Hold and ramp: anchor 100, then freeze=1 for 3 xfers with in=30000 -> outputs 100,100,100; then freeze=0, in=500 -> 200, 300, 400, 500; freeze_events=1, blanked_count=3.
REQ-035 Floor rounding: anchor 0, one freeze xfer, then freeze=0 with in=-1 -> k=1 output -1; in=1 -> k=1 output 0.
REQ-036 Re-freeze in RAMP: anchor 100, in=500, after output 200 freeze=1 -> output 200, state HOLD, freeze_events=2; after release, ramp starts from anchor 200.
REQ-037 Back-pressure: out_ready=0 for 5 cycles with in_valid=1, freeze toggling -> in_ready=0, out_sample, state and counters unchanged.
REQ-038 Async reset: rst_n low in RAMP between clock edges -> outputs zero without a clock edge; post-release first sample 7 -> output 7.
